lsu_ctrl: RTL and testbench

Load/store sequencer between the decode/address stage and the data memory port. Accepts one load or store per request: effective address (`dataadd`), funct3 and rs2data. Produces the word-aligned memory access with byte enables and lane-replicated write data, runs the request/acknowledge handshake with a timeout, and returns the sign- or zero-extended load result. Stalls the core through `ready` while an access is in flight.

---
 rtl/lsu_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the address stage and the data memory port.
// Takes one load or store per request. It drives a word-aligned memory access with
// byte enables and lane-replicated store data, and runs req/ack with a timeout.
// It returns the sign- or zero-extended load result. ready stalls the core while
// an access is in flight.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid, ls_op     request strobe and op (01 load, 10 store, else ignored)
//   funct3, dataadd      RV32I width code, effective byte address
//   rs2data              store data
//   ready                high in IDLE (and during reset)
//   done, err, rd_data   completion pulse, error flag, load result
//   mem_req/we/addr/be/wdata, mem_ack, mem_rdata   memory port
//
// Build option: define MISALIGN_TRAP_EN to make misaligned halfword and word
// accesses complete immediately with err instead of ignoring the low address bits.
module lsu_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned TO_W           = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [1:0]  ls_op,
   input  logic [2:0]  funct3,
   input  logic [31:0] dataadd,
   input  logic [31:0] rs2data,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [31:0] rd_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t          r_state;
   logic [1:0]      r_op;
   logic [2:0]      r_f3;
   logic [1:0]      r_alo;
   logic [TO_W-1:0] r_cnt;

   logic        w_accept;
   logic        w_legal;
   logic        w_misalign;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ld_ext;
   logic        w_timeout;

   // ready is the only unregistered output; forced high while reset is asserted
   assign ready     = rst | (r_state == S_IDLE);
   assign w_accept  = (r_state == S_IDLE) && req_valid &&
                      ((ls_op == OP_LOAD) || (ls_op == OP_STORE));
   assign w_timeout = (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // funct3 legality per op
   always_comb begin
      w_legal = 1'b0;
      if (ls_op == OP_LOAD) begin
         case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
            default:                                w_legal = 1'b0;
         endcase
      end else if (ls_op == OP_STORE) begin
         case (funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            default:                w_legal = 1'b0;
         endcase
      end
   end

   // misalignment check, only active in the trapping build
   always_comb begin
      w_misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
      case (funct3[1:0])
         2'b01:   w_misalign = dataadd[0];
         2'b10:   w_misalign = |dataadd[1:0];
         default: w_misalign = 1'b0;
      endcase
`endif
   end

   // byte enables and replicated store data; low bits beyond the width are ignored
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = 32'd0;
      case (funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << dataadd[1:0];
            w_wdata = {4{rs2data[7:0]}};
         end
         2'b01: begin
            w_be    = dataadd[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{rs2data[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = rs2data;
         end
      endcase
      if (ls_op != OP_STORE) w_wdata = 32'd0;
   end

   // lane select and extension of the returned word using the latched request
   always_comb begin
      w_byte = mem_rdata[7:0];
      case (r_alo)
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         2'd3:    w_byte = mem_rdata[31:24];
         default: w_byte = mem_rdata[7:0];
      endcase
      w_half = r_alo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (r_f3)
         3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ld_ext = {24'd0, w_byte};
         3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
         3'b101:  w_ld_ext = {16'd0, w_half};
         default: w_ld_ext = mem_rdata;
      endcase
   end

   // sequencer: state, timeout counter and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_op      <= 2'd0;
         r_f3      <= 3'd0;
         r_alo     <= 2'd0;
         r_cnt     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         rd_data   <= 32'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_be    <= 4'd0;
         mem_wdata <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (w_accept) begin
                  r_op  <= ls_op;
                  r_f3  <= funct3;
                  r_alo <= dataadd[1:0];
                  r_cnt <= '0;
                  if (!w_legal || w_misalign) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                     err     <= 1'b1;
                     rd_data <= 32'd0;
                  end else begin
                     r_state   <= S_ACCESS;
                     mem_req   <= 1'b1;
                     mem_we    <= (ls_op == OP_STORE);
                     mem_addr  <= {dataadd[31:2], 2'b00};
                     mem_be    <= w_be;
                     mem_wdata <= w_wdata;
                  end
               end
            end
            S_ACCESS: begin
               // ack takes priority over a coincident timeout
               if (mem_ack || w_timeout) begin
                  r_state   <= S_DONE;
                  done      <= 1'b1;
                  err       <= ~mem_ack;
                  rd_data   <= (mem_ack && (r_op == OP_LOAD)) ? w_ld_ext : 32'd0;
                  r_cnt     <= '0;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= 32'd0;
                  mem_be    <= 4'd0;
                  mem_wdata <= 32'd0;
               end else begin
                  r_cnt <= r_cnt + TO_W'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               done    <= 1'b0;
               err     <= 1'b0;
               r_cnt   <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [1:0]  ls_op;
   logic [2:0]  funct3;
   logic [31:0] dataadd;
   logic [31:0] rs2data;
   logic        ready;
   logic        done;
   logic        err;
   logic [31:0] rd_data;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;
   int req_cycles;

   lsu_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .ls_op     (ls_op),
      .funct3    (funct3),
      .dataadd   (dataadd),
      .rs2data   (rs2data),
      .ready     (ready),
      .done      (done),
      .err       (err),
      .rd_data   (rd_data),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      ls_op     = op;
      funct3    = f3;
      dataadd   = a;
      rs2data   = d;
      tick();
      req_valid = 1'b0;
      ls_op     = 2'b00;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; ls_op = 2'b00; funct3 = 3'b000;
      dataadd = 32'd0; rs2data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      #1;
      chk("ready_in_reset", 32'(ready), 32'd1);
      tick(); tick();
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      rst = 1'b0;
      tick();

      // no-op ls_op is ignored
      req_valid = 1'b1; ls_op = 2'b00; funct3 = 3'b010;
      tick();
      req_valid = 1'b0;
      chk("noop_ready", 32'(ready), 32'd1);
      chk("noop_mem_req", 32'(mem_req), 32'd0);

      // SW 0x100, ack two cycles after mem_req rises
      issue(2'b10, 3'b010, 32'h100, 32'hDEADBEEF);
      chk("sw_mem_req", 32'(mem_req), 32'd1);
      chk("sw_mem_we", 32'(mem_we), 32'd1);
      chk("sw_mem_addr", mem_addr, 32'h100);
      chk("sw_mem_be", 32'(mem_be), 32'hF);
      chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("sw_ready", 32'(ready), 32'd0);
      tick(); tick();
      chk("sw_ready_wait", 32'(ready), 32'd0);
      chk("sw_req_held", 32'(mem_req), 32'd1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("sw_done", 32'(done), 32'd1);
      chk("sw_err", 32'(err), 32'd0);
      chk("sw_req_drop", 32'(mem_req), 32'd0);
      chk("sw_ready_done", 32'(ready), 32'd0);
      chk("sw_rd_data", rd_data, 32'd0);
      tick();
      chk("sw_done_clear", 32'(done), 32'd0);
      chk("sw_ready_back", 32'(ready), 32'd1);

      // LB / LBU at 0x103
      issue(2'b01, 3'b000, 32'h103, 32'd0);
      chk("lb_mem_be", 32'(mem_be), 32'b1000);
      chk("lb_mem_we", 32'(mem_we), 32'd0);
      chk("lb_mem_addr", mem_addr, 32'h100);
      mem_ack = 1'b1; mem_rdata = 32'h80FF0000;
      tick();
      mem_ack = 1'b0;
      chk("lb_done", 32'(done), 32'd1);
      chk("lb_rd_data", rd_data, 32'hFFFFFF80);
      tick();
      issue(2'b01, 3'b100, 32'h103, 32'd0);
      chk("lbu_mem_be", 32'(mem_be), 32'b1000);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("lbu_rd_data", rd_data, 32'h00000080);
      tick();

      // SH / LH at 0x202
      issue(2'b10, 3'b001, 32'h202, 32'h1234ABCD);
      chk("sh_mem_be", 32'(mem_be), 32'b1100);
      chk("sh_mem_wdata", mem_wdata, 32'hABCDABCD);
      chk("sh_mem_addr", mem_addr, 32'h200);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("sh_done", 32'(done), 32'd1);
      tick();
      issue(2'b01, 3'b001, 32'h202, 32'd0);
      chk("lh_mem_be", 32'(mem_be), 32'b1100);
      mem_ack = 1'b1; mem_rdata = 32'h80015555;
      tick();
      mem_ack = 1'b0;
      chk("lh_rd_data", rd_data, 32'hFFFF8001);
      tick();

      // load with no ack times out after 16 request cycles
      issue(2'b01, 3'b010, 32'h300, 32'd0);
      req_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (mem_req !== 1'b1) break;
         req_cycles++;
         tick();
      end
      chk("to_req_cycles", 32'(req_cycles), 32'd16);
      chk("to_done", 32'(done), 32'd1);
      chk("to_err", 32'(err), 32'd1);
      chk("to_rd_data", rd_data, 32'd0);
      tick();
      chk("to_ready", 32'(ready), 32'd1);
      chk("to_err_clear", 32'(err), 32'd0);

      // ack in the last allowed cycle beats the timeout
      issue(2'b01, 3'b010, 32'h400, 32'd0);
      for (int i = 0; i < 15; i++) tick();
      chk("co_req_last", 32'(mem_req), 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_ack = 1'b0;
      chk("co_done", 32'(done), 32'd1);
      chk("co_err", 32'(err), 32'd0);
      chk("co_rd_data", rd_data, 32'h12345678);
      tick();

      // LW at 0x101
      issue(2'b01, 3'b010, 32'h101, 32'd0);
`ifdef MISALIGN_TRAP_EN
      chk("lwm_done", 32'(done), 32'd1);
      chk("lwm_err", 32'(err), 32'd1);
      chk("lwm_mem_req", 32'(mem_req), 32'd0);
      tick();
      chk("lwm_ready", 32'(ready), 32'd1);
`else
      chk("lwm_mem_addr", mem_addr, 32'h100);
      chk("lwm_mem_be", 32'(mem_be), 32'hF);
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      mem_ack = 1'b0;
      chk("lwm_err", 32'(err), 32'd0);
      chk("lwm_rd_data", rd_data, 32'hCAFEF00D);
      tick();
`endif

      // reset during ACCESS discards the access; late ack ignored
      issue(2'b10, 3'b000, 32'h501, 32'h000000A5);
      chk("sb_mem_be", 32'(mem_be), 32'b0010);
      chk("sb_mem_wdata", mem_wdata, 32'hA5A5A5A5);
      tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(ready), 32'd1);
      tick();
      rst = 1'b0;
      chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("late_ack_done", 32'(done), 32'd0);
      chk("late_ack_ready", 32'(ready), 32'd1);
      chk("late_ack_mem_req", 32'(mem_req), 32'd0);

      // illegal funct3: load 011, store 100
      issue(2'b01, 3'b011, 32'h600, 32'd0);
      chk("ill_ld_done", 32'(done), 32'd1);
      chk("ill_ld_err", 32'(err), 32'd1);
      chk("ill_ld_mem_req", 32'(mem_req), 32'd0);
      tick();
      chk("ill_ld_ready", 32'(ready), 32'd1);
      chk("ill_ld_done_clear", 32'(done), 32'd0);
      issue(2'b10, 3'b100, 32'h600, 32'd0);
      chk("ill_st_err", 32'(err), 32'd1);
      chk("ill_st_mem_req", 32'(mem_req), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
